// File: rtl/huffman_param.sv
// huffman_param: burst symbol histogram followed by an iterative sort/merge
// Huffman code builder. Publishes per-symbol counts, then per-symbol
// right-aligned codes and length masks.
module huffman_param #(
  parameter int NUM_SYM = 6,
  parameter int CNT_W   = 8,
  parameter int CODE_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        gray_valid,
  input  logic [7:0]                  gray_data,
  output logic                        CNT_valid,
  output logic [NUM_SYM*CNT_W-1:0]    CNT,
  output logic                        code_valid,
  output logic [NUM_SYM*CODE_W-1:0]   HC,
  output logic [NUM_SYM*CODE_W-1:0]   M
);

  // Merged node counts never overflow: at most 16 leaves of 2^CNT_W-1 each.
  localparam int SUM_W  = CNT_W + 4;
  localparam int IDX_W  = $clog2(NUM_SYM);
  localparam int NUM_W  = $clog2(NUM_SYM + 1);
  // Tie-break keys: merged nodes use 0..NUM_SYM-2 (newest smallest),
  // leaves use NUM_SYM+k so they rank behind merged nodes of equal count
  // and among themselves by symbol index.
  localparam int TB_W   = $clog2(2 * NUM_SYM);
  localparam int LEN_W  = $clog2(CODE_W + 1);
  localparam int PASS_W = $clog2(NUM_SYM);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_SORT  = 3'd2,
    S_MERGE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q      [NUM_SYM];
  logic [SUM_W-1:0]     node_cnt_q [NUM_SYM];
  logic [NUM_SYM-1:0]   node_mem_q [NUM_SYM];
  logic [TB_W-1:0]      node_tb_q  [NUM_SYM];
  logic [NUM_W-1:0]     n_q;
  logic [PASS_W-1:0]    pass_q;
  logic [TB_W-1:0]      tb_next_q;
  logic [CODE_W-1:0]    code_q     [NUM_SYM];
  logic [LEN_W-1:0]     len_q      [NUM_SYM];
  logic [NUM_SYM*CODE_W-1:0] hc_q;
  logic [NUM_SYM*CODE_W-1:0] m_q;
  logic                 cnt_valid_q;
  logic                 code_valid_q;

  // Next-state values produced by one sort pass and by one merge step.
  logic [SUM_W-1:0]     srt_cnt_d  [NUM_SYM];
  logic [NUM_SYM-1:0]   srt_mem_d  [NUM_SYM];
  logic [TB_W-1:0]      srt_tb_d   [NUM_SYM];
  logic [CODE_W-1:0]    code_d     [NUM_SYM];
  logic [LEN_W-1:0]     len_d      [NUM_SYM];
  logic [IDX_W-1:0]     idx_a_s;
  logic [IDX_W-1:0]     idx_b_s;
  logic [NUM_SYM-1:0]   mem_a_s;
  logic [NUM_SYM-1:0]   mem_b_s;
  logic [SUM_W-1:0]     merged_cnt_s;
  logic                 sym_ok_s;
  logic [IDX_W-1:0]     sym_idx_s;

  // True when node a must sit ahead of node b in the descending list.
  function automatic logic node_before(input logic [SUM_W-1:0] cnt_a,
                                       input logic [TB_W-1:0]  tb_a,
                                       input logic [SUM_W-1:0] cnt_b,
                                       input logic [TB_W-1:0]  tb_b);
    node_before = (cnt_a > cnt_b) || ((cnt_a == cnt_b) && (tb_a < tb_b));
  endfunction

  // Ones in the low len bits; len == CODE_W wraps to all ones.
  function automatic logic [CODE_W-1:0] mask_of(input logic [LEN_W-1:0] len);
    mask_of = (CODE_W'(1) << len) - CODE_W'(1);
  endfunction

  // Decode the incoming sample into a counter index and a legality flag.
  always_comb begin
    sym_ok_s  = (gray_data != 8'd0) && (gray_data <= 8'(NUM_SYM));
    sym_idx_s = IDX_W'(gray_data - 8'd1);
  end

  // One odd-even transposition pass over the active node list.
  always_comb begin
    srt_cnt_d = node_cnt_q;
    srt_mem_d = node_mem_q;
    srt_tb_d  = node_tb_q;
    for (int j = 0; j < NUM_SYM - 1; j++) begin
      if (((j % 2) == int'(pass_q[0])) && (NUM_W'(j + 1) < n_q)) begin
        if (node_before(node_cnt_q[j+1], node_tb_q[j+1], node_cnt_q[j], node_tb_q[j])) begin
          srt_cnt_d[j]   = node_cnt_q[j+1];
          srt_mem_d[j]   = node_mem_q[j+1];
          srt_tb_d[j]    = node_tb_q[j+1];
          srt_cnt_d[j+1] = node_cnt_q[j];
          srt_mem_d[j+1] = node_mem_q[j];
          srt_tb_d[j+1]  = node_tb_q[j];
        end else begin
          srt_cnt_d[j] = srt_cnt_d[j];
        end
      end else begin
        srt_cnt_d[j] = srt_cnt_d[j];
      end
    end
  end

  // Merge the last two nodes: prepend 0 to the second-to-last, 1 to the last.
  always_comb begin
    idx_a_s      = IDX_W'(n_q - NUM_W'(2));
    idx_b_s      = IDX_W'(n_q - NUM_W'(1));
    mem_a_s      = node_mem_q[idx_a_s];
    mem_b_s      = node_mem_q[idx_b_s];
    merged_cnt_s = node_cnt_q[idx_a_s] + node_cnt_q[idx_b_s];
    for (int s = 0; s < NUM_SYM; s++) begin
      code_d[s] = code_q[s];
      len_d[s]  = len_q[s];
      if (mem_a_s[s]) begin
        len_d[s] = len_q[s] + LEN_W'(1);
      end else if (mem_b_s[s]) begin
        code_d[s] = code_q[s] | (CODE_W'(1) << len_q[s]);
        len_d[s]  = len_q[s] + LEN_W'(1);
      end else begin
        len_d[s] = len_q[s];
      end
    end
  end

  // Main controller: counting, sort/merge iteration and output publishing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      n_q          <= NUM_W'(NUM_SYM);
      pass_q       <= '0;
      tb_next_q    <= '0;
      hc_q         <= '0;
      m_q          <= '0;
      cnt_valid_q  <= 1'b0;
      code_valid_q <= 1'b0;
      for (int k = 0; k < NUM_SYM; k++) begin
        cnt_q[k]      <= '0;
        node_cnt_q[k] <= '0;
        node_mem_q[k] <= '0;
        node_tb_q[k]  <= '0;
        code_q[k]     <= '0;
        len_q[k]      <= '0;
      end
    end else begin
      cnt_valid_q  <= 1'b0;
      code_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gray_valid) begin
            for (int k = 0; k < NUM_SYM; k++) begin
              cnt_q[k] <= '0;
            end
            if (sym_ok_s) begin
              cnt_q[sym_idx_s] <= CNT_W'(1);
            end
            hc_q    <= '0;
            m_q     <= '0;
            state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (gray_valid) begin
            if (sym_ok_s && (cnt_q[sym_idx_s] != '1)) begin
              cnt_q[sym_idx_s] <= cnt_q[sym_idx_s] + CNT_W'(1);
            end
          end else begin
            // Burst over: publish counts and seed the node list with leaves.
            cnt_valid_q <= 1'b1;
            for (int k = 0; k < NUM_SYM; k++) begin
              node_cnt_q[k] <= SUM_W'(cnt_q[k]);
              node_mem_q[k] <= NUM_SYM'(1) << k;
              node_tb_q[k]  <= TB_W'(NUM_SYM + k);
              code_q[k]     <= '0;
              len_q[k]      <= '0;
            end
            n_q       <= NUM_W'(NUM_SYM);
            pass_q    <= '0;
            tb_next_q <= TB_W'(NUM_SYM - 2);
            state_q   <= S_SORT;
          end
        end
        S_SORT: begin
          node_cnt_q <= srt_cnt_d;
          node_mem_q <= srt_mem_d;
          node_tb_q  <= srt_tb_d;
          // NUM_SYM passes fully order up to NUM_SYM active nodes.
          if (pass_q == PASS_W'(NUM_SYM - 1)) begin
            pass_q  <= '0;
            state_q <= S_MERGE;
          end else begin
            pass_q <= pass_q + PASS_W'(1);
          end
        end
        S_MERGE: begin
          node_cnt_q[idx_a_s] <= merged_cnt_s;
          node_mem_q[idx_a_s] <= mem_a_s | mem_b_s;
          node_tb_q[idx_a_s]  <= tb_next_q;
          tb_next_q           <= tb_next_q - TB_W'(1);
          code_q              <= code_d;
          len_q               <= len_d;
          if (n_q == NUM_W'(2)) begin
            n_q     <= NUM_W'(NUM_SYM);
            state_q <= S_DONE;
          end else begin
            n_q     <= n_q - NUM_W'(1);
            state_q <= S_SORT;
          end
        end
        S_DONE: begin
          for (int s = 0; s < NUM_SYM; s++) begin
            hc_q[s*CODE_W +: CODE_W] <= code_q[s];
            m_q[s*CODE_W +: CODE_W]  <= mask_of(len_q[s]);
          end
          code_valid_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SYM; k++) begin : g_cnt_pack
    assign CNT[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  assign CNT_valid  = cnt_valid_q;
  assign code_valid = code_valid_q;
  assign HC         = hc_q;
  assign M          = m_q;

endmodule

// File: tb/tb_huffman_param.sv
// Bench for huffman_param: three instances (6/8/8, 6/4/8, 2/8/8) share one
// stimulus stream; each is compared with a list-based Huffman reference.
module tb_huffman_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gv;
  logic [7:0]  gd;

  logic        cv_a, kv_a, cv_b, kv_b, cv_c, kv_c;
  logic [47:0] cnt_a, hc_a, m_a;
  logic [23:0] cnt_b;
  logic [47:0] hc_b, m_b;
  logic [15:0] cnt_c, hc_c, m_c;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  huffman_param #(.NUM_SYM(6), .CNT_W(8), .CODE_W(8)) u_a (
    .clk(clk), .reset(rst_n), .gray_valid(gv), .gray_data(gd),
    .CNT_valid(cv_a), .CNT(cnt_a), .code_valid(kv_a), .HC(hc_a), .M(m_a));
  huffman_param #(.NUM_SYM(6), .CNT_W(4), .CODE_W(8)) u_b (
    .clk(clk), .reset(rst_n), .gray_valid(gv), .gray_data(gd),
    .CNT_valid(cv_b), .CNT(cnt_b), .code_valid(kv_b), .HC(hc_b), .M(m_b));
  huffman_param #(.NUM_SYM(2), .CNT_W(8), .CODE_W(8)) u_c (
    .clk(clk), .reset(rst_n), .gray_valid(gv), .gray_data(gd),
    .CNT_valid(cv_c), .CNT(cnt_c), .code_valid(kv_c), .HC(hc_c), .M(m_c));

  typedef struct packed {
    logic [7:0]      id;
    logic [2:0]      nrun;
    logic [5:0][7:0] rsym;
    logic [5:0][7:0] rrep;
    logic            pulse;
    logic [1:0]      inst;
    logic            chk_code;
    logic [5:0][7:0] ecnt;
    logic [5:0][7:0] ehc;
    logic [5:0][7:0] em;
  } vec_t;

  typedef struct {
    int c;
    int mem;
  } mnode_t;

  vec_t tbl [5];

  function automatic int ns(input int i);
    return (i == 2) ? 2 : 6;
  endfunction

  function automatic int cw(input int i);
    return (i == 1) ? 4 : 8;
  endfunction

  function automatic logic [5:0][7:0] pk6(input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6);
    logic [5:0][7:0] v;
    v[0] = 8'(a1); v[1] = 8'(a2); v[2] = 8'(a3);
    v[3] = 8'(a4); v[4] = 8'(a5); v[5] = 8'(a6);
    return v;
  endfunction

  function automatic int g_cv(input int i);
    case (i)
      0: return int'(cv_a);
      1: return int'(cv_b);
      default: return int'(cv_c);
    endcase
  endfunction

  function automatic int g_kv(input int i);
    case (i)
      0: return int'(kv_a);
      1: return int'(kv_b);
      default: return int'(kv_c);
    endcase
  endfunction

  function automatic int g_cnt(input int i, input int k);
    case (i)
      0: return int'(cnt_a[k*8 +: 8]);
      1: return int'(cnt_b[k*4 +: 4]);
      default: return int'(cnt_c[k*8 +: 8]);
    endcase
  endfunction

  function automatic int g_hc(input int i, input int k);
    case (i)
      0: return int'(hc_a[k*8 +: 8]);
      1: return int'(hc_b[k*8 +: 8]);
      default: return int'(hc_c[k*8 +: 8]);
    endcase
  endfunction

  function automatic int g_m(input int i, input int k);
    case (i)
      0: return int'(m_a[k*8 +: 8]);
      1: return int'(m_b[k*8 +: 8]);
      default: return int'(m_c[k*8 +: 8]);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Reference: saturating histogram, then a descending list where each merged
  // node is inserted ahead of all nodes with equal count.
  task automatic model(input int n, input int w, input int syms[$],
                       output int cnt[16], output int hc[16], output int ln[16]);
    mnode_t lst[$];
    mnode_t a, b, nn;
    int maxc, pos;
    bit found;
    maxc = (1 << w) - 1;
    for (int k = 0; k < 16; k++) begin cnt[k] = 0; hc[k] = 0; ln[k] = 0; end
    foreach (syms[i])
      if (syms[i] >= 1 && syms[i] <= n && cnt[syms[i]-1] < maxc) cnt[syms[i]-1]++;
    for (int v = maxc; v >= 0; v--)
      for (int k = 0; k < n; k++)
        if (cnt[k] == v) begin nn.c = v; nn.mem = 1 << k; lst.push_back(nn); end
    while (lst.size() > 1) begin
      b = lst.pop_back();
      a = lst.pop_back();
      for (int k = 0; k < n; k++) begin
        if (a.mem[k]) ln[k]++;
        if (b.mem[k]) begin hc[k] |= (1 << ln[k]); ln[k]++; end
      end
      nn.c = a.c + b.c;
      nn.mem = a.mem | b.mem;
      pos = lst.size();
      found = 1'b0;
      for (int i = 0; i < lst.size(); i++)
        if (!found && lst[i].c <= nn.c) begin pos = i; found = 1'b1; end
      lst.insert(pos, nn);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_a"}, int'(|{cnt_a, hc_a, m_a, cv_a, kv_a}), 0);
    chk({nm, "_b"}, int'(|{cnt_b, hc_b, m_b, cv_b, kv_b}), 0);
    chk({nm, "_c"}, int'(|{cnt_c, hc_c, m_c, cv_c, kv_c}), 0);
  endtask

  task automatic run_burst(input int id, input int syms[$], input bit pulse,
                           input int ci, input bit cc, input logic [5:0][7:0] ecnt,
                           input logic [5:0][7:0] ehc, input logic [5:0][7:0] em);
    int ec[3][16];
    int eh[3][16];
    int emk[3][16];
    int tc[16], th[16], tl[16];
    int seen[3], lat[3];
    for (int i = 0; i < 3; i++) begin
      model(ns(i), cw(i), syms, tc, th, tl);
      for (int k = 0; k < 16; k++) begin
        ec[i][k] = tc[k]; eh[i][k] = th[k]; emk[i][k] = (1 << tl[k]) - 1;
      end
      seen[i] = 0; lat[i] = 0;
    end
    for (int i = 0; i <= syms.size(); i++) begin
      @(negedge clk);
      if (i == 1) chk($sformatf("t%0d_hc_clear", id), int'(|{hc_a, m_a}), 0);
      if (i < syms.size()) begin gv = 1'b1; gd = 8'(syms[i]); end
      else begin gv = 1'b0; gd = 8'd0; end
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t%0d_i%0d_cnt_valid", id, i), g_cv(i), 1);
      for (int k = 0; k < ns(i); k++)
        chk($sformatf("t%0d_i%0d_cnt%0d", id, i, k+1), g_cnt(i, k), ec[i][k]);
    end
    if (ci >= 0)
      for (int k = 0; k < ns(ci); k++)
        chk($sformatf("t%0d_const_cnt%0d", id, k+1), g_cnt(ci, k), int'(ecnt[k]));
    if (pulse) begin gv = 1'b1; gd = 8'($urandom_range(1, 6)); end
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (pulse && c < 2) gd = 8'($urandom_range(1, 6));
      else begin gv = 1'b0; gd = 8'd0; end
      if (c == 1)
        for (int i = 0; i < 3; i++)
          chk($sformatf("t%0d_i%0d_cnt_valid_pulse", id, i), g_cv(i), 0);
      for (int i = 0; i < 3; i++) begin
        if (g_kv(i) == 1) begin
          seen[i]++;
          lat[i] = c;
          for (int k = 0; k < ns(i); k++) begin
            chk($sformatf("t%0d_i%0d_hc%0d", id, i, k+1), g_hc(i, k), eh[i][k]);
            chk($sformatf("t%0d_i%0d_m%0d", id, i, k+1), g_m(i, k), emk[i][k]);
            if (cc && i == ci) begin
              chk($sformatf("t%0d_const_hc%0d", id, k+1), g_hc(i, k), int'(ehc[k]));
              chk($sformatf("t%0d_const_m%0d", id, k+1), g_m(i, k), int'(em[k]));
            end
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t%0d_i%0d_code_valid_pulses", id, i), seen[i], 1);
      chk($sformatf("t%0d_i%0d_latency_%0d_ok", id, i, lat[i]),
          (lat[i] > 0 && lat[i] <= ns(i) * (ns(i) + 2)) ? 1 : 0, 1);
    end
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t%0d_hold_hc%0d", id, k+1), g_hc(0, k), eh[0][k]);
      chk($sformatf("t%0d_hold_cnt%0d", id, k+1), g_cnt(0, k), ec[0][k]);
    end
  endtask

  initial begin
    int q[$];
    int kv_seen;
    logic [5:0][7:0] z;
    z = '0;

    tbl[0] = '{id: 8'd2, nrun: 3'd6, rsym: pk6(1,2,3,4,5,6), rrep: pk6(4,3,2,1,1,1),
               pulse: 1'b0, inst: 2'd0, chk_code: 1'b1, ecnt: pk6(4,3,2,1,1,1),
               ehc: pk6(0,2,2,3,6,7), em: pk6(3,3,7,7,7,7)};
    tbl[1] = '{id: 8'd3, nrun: 3'd4, rsym: pk6(0,7,9,2,0,0), rrep: pk6(1,1,1,1,0,0),
               pulse: 1'b0, inst: 2'd0, chk_code: 1'b0, ecnt: pk6(0,1,0,0,0,0),
               ehc: z, em: z};
    tbl[2] = '{id: 8'd4, nrun: 3'd1, rsym: pk6(1,0,0,0,0,0), rrep: pk6(20,0,0,0,0,0),
               pulse: 1'b0, inst: 2'd1, chk_code: 1'b0, ecnt: pk6(15,0,0,0,0,0),
               ehc: z, em: z};
    tbl[3] = '{id: 8'd5, nrun: 3'd6, rsym: pk6(1,2,3,4,5,6), rrep: pk6(4,3,2,1,1,1),
               pulse: 1'b1, inst: 2'd0, chk_code: 1'b1, ecnt: pk6(4,3,2,1,1,1),
               ehc: pk6(0,2,2,3,6,7), em: pk6(3,3,7,7,7,7)};
    tbl[4] = '{id: 8'd6, nrun: 3'd2, rsym: pk6(1,2,0,0,0,0), rrep: pk6(5,3,0,0,0,0),
               pulse: 1'b0, inst: 2'd2, chk_code: 1'b1, ecnt: pk6(5,3,0,0,0,0),
               ehc: pk6(0,1,0,0,0,0), em: pk6(1,1,0,0,0,0)};

    rst_n = 1'b0; gv = 1'b0; gd = 8'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset_init");
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      q.delete();
      for (int r = 0; r < int'(tbl[t].nrun); r++)
        for (int n = 0; n < int'(tbl[t].rrep[r]); n++) q.push_back(int'(tbl[t].rsym[r]));
      run_burst(int'(tbl[t].id), q, tbl[t].pulse, int'(tbl[t].inst), tbl[t].chk_code,
                tbl[t].ecnt, tbl[t].ehc, tbl[t].em);
    end

    // Reset held for two cycles in the middle of a burst.
    @(negedge clk); gv = 1'b1; gd = 8'd1;
    @(negedge clk); gd = 8'd2;
    @(negedge clk); gd = 8'd3; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset_mid_count");
    rst_n = 1'b1; gv = 1'b0; gd = 8'd0;
    q = '{3, 3, 1, 5};
    run_burst(10, q, 1'b0, -1, 1'b0, z, z, z);

    // Reset during the build: no code_valid may follow.
    q = '{2, 2, 4, 6, 6, 6};
    foreach (q[i]) begin @(negedge clk); gv = 1'b1; gd = 8'(q[i]); end
    @(negedge clk); gv = 1'b0; gd = 8'd0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset_mid_build");
    rst_n = 1'b1;
    kv_seen = 0;
    repeat (60) begin
      @(negedge clk);
      kv_seen += int'(kv_a) + int'(kv_b) + int'(kv_c);
    end
    chk("reset_mid_build_no_code", kv_seen, 0);

    for (int r = 0; r < 12; r++) begin
      int len;
      q.delete();
      len = int'($urandom_range(1, 30));
      for (int i = 0; i < len; i++)
        q.push_back(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3))
                                                 : int'($urandom_range(0, 9)));
      run_burst(100 + r, q, 1'($urandom_range(0, 1)), -1, 1'b0, z, z, z);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
